// File: rtl/gty_rx_frame_aligner.sv
// gty_rx_frame_aligner
//   Recovers word and frame alignment from the raw 80-bit GTY RX parallel
//   stream. A bit-slip search (HUNT) looks for SYNC_WORD at every bit offset.
//   The candidate alignment is then confirmed over VERIFY_COUNT headers
//   (VERIFY) and tracked in LOCKED, where payload words go out on an
//   AXI-Stream-like master with no back-pressure.
//
// Ports
//   m_axis_aclk          GTY RX user clock (single clock domain)
//   rx_reset_in          asynchronous active-high reset
//   gtwiz_userdata_rx_in raw RX parallel data, 80 bits
//   rx_active_in         RX clocking active and RX reset done
//   m_axis_tdata         aligned payload word
//   m_axis_tvalid        payload valid (the GT cannot be stalled, so no tready)
//   m_axis_tlast         last payload word of a frame
//   rx_locked_out        high while in LOCKED
//   bit_offset_out       current slip offset, 0..79
//   hdr_err_count_out    header mismatches seen in LOCKED, saturating
//   lock_loss_count_out  LOCKED->HUNT transitions, saturating
module gty_rx_frame_aligner #(
    parameter logic [15:0] SYNC_WORD    = 16'hA5C3,
    parameter int unsigned FRAME_LEN    = 8,
    parameter int unsigned VERIFY_COUNT = 4,
    parameter int unsigned MISS_LIMIT   = 3
) (
    input  logic        m_axis_aclk,
    input  logic        rx_reset_in,
    input  logic [79:0] gtwiz_userdata_rx_in,
    input  logic        rx_active_in,
    output logic [79:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        rx_locked_out,
    output logic [6:0]  bit_offset_out,
    output logic [15:0] hdr_err_count_out,
    output logic [7:0]  lock_loss_count_out
);

    localparam logic [7:0] WCNT_LAST  = 8'(FRAME_LEN - 1);
    localparam logic [7:0] GOOD_NEED  = 8'(VERIFY_COUNT);
    localparam logic [7:0] MISS_NEED  = 8'(MISS_LIMIT);
    localparam logic [6:0] OFFSET_MAX = 7'd79;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    state_t      state_q, state_d;
    logic [79:0] cur_q, prev_q;
    logic [6:0]  offset_q, offset_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [7:0]  good_q, good_d;
    logic [7:0]  miss_q, miss_d;
    logic [15:0] hdr_err_q, hdr_err_d;
    logic [7:0]  loss_q, loss_d;
    logic [79:0] tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        locked_q, locked_d;

    logic [159:0] window;
    logic [79:0]  aligned;
    logic         hdr_match;
    logic [7:0]   wcnt_next;
    logic [6:0]   offset_inc;
    logic [7:0]   good_inc;
    logic [7:0]   miss_inc;

    // prev holds the older word, so the offset selects how far into the
    // newer word the aligned window straddles.
    assign window     = {cur_q, prev_q};
    assign aligned    = window[offset_q +: 80];
    assign hdr_match  = (aligned[79:64] == SYNC_WORD);
    assign wcnt_next  = (wcnt_q == WCNT_LAST) ? '0 : wcnt_q + 8'd1;
    assign offset_inc = (offset_q == OFFSET_MAX) ? '0 : offset_q + 7'd1;
    assign good_inc   = good_q + 8'd1;
    assign miss_inc   = miss_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        wcnt_d    = wcnt_q;
        good_d    = good_q;
        miss_d    = miss_q;
        hdr_err_d = hdr_err_q;
        loss_d    = loss_q;
        tdata_d   = tdata_q;
        tvalid_d  = 1'b0;
        tlast_d   = 1'b0;

        if (!rx_active_in) begin
            // Link not usable: restart the search but keep the offset and
            // the statistics counters.
            state_d = HUNT;
            wcnt_d  = '0;
            good_d  = '0;
            miss_d  = '0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    if (hdr_match) begin
                        state_d = VERIFY;
                        wcnt_d  = 8'd1;
                        good_d  = 8'd1;
                    end else begin
                        offset_d = offset_inc;
                    end
                end

                VERIFY: begin
                    wcnt_d = wcnt_next;
                    if (wcnt_q == '0) begin
                        if (hdr_match) begin
                            good_d = good_inc;
                            if (good_inc == GOOD_NEED) begin
                                state_d = LOCKED;
                                miss_d  = '0;
                            end
                        end else begin
                            state_d  = HUNT;
                            offset_d = offset_inc;
                            wcnt_d   = '0;
                            good_d   = '0;
                        end
                    end
                end

                LOCKED: begin
                    // Frame timing free-runs; a bad header is counted but the
                    // payload around it is still delivered.
                    wcnt_d = wcnt_next;
                    if (wcnt_q == '0) begin
                        if (hdr_match) begin
                            miss_d = '0;
                        end else begin
                            miss_d = miss_inc;
                            if (hdr_err_q != '1) begin
                                hdr_err_d = hdr_err_q + 16'd1;
                            end
                            if (miss_inc == MISS_NEED) begin
                                state_d = HUNT;
                                wcnt_d  = '0;
                                good_d  = '0;
                                miss_d  = '0;
                                if (loss_q != '1) begin
                                    loss_d = loss_q + 8'd1;
                                end
                            end
                        end
                    end else begin
                        tdata_d  = aligned;
                        tvalid_d = 1'b1;
                        tlast_d  = (wcnt_q == WCNT_LAST);
                    end
                end

                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge m_axis_aclk or posedge rx_reset_in) begin
        if (rx_reset_in) begin
            state_q   <= HUNT;
            cur_q     <= '0;
            prev_q    <= '0;
            offset_q  <= '0;
            wcnt_q    <= '0;
            good_q    <= '0;
            miss_q    <= '0;
            hdr_err_q <= '0;
            loss_q    <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= gtwiz_userdata_rx_in;
            prev_q    <= cur_q;
            offset_q  <= offset_d;
            wcnt_q    <= wcnt_d;
            good_q    <= good_d;
            miss_q    <= miss_d;
            hdr_err_q <= hdr_err_d;
            loss_q    <= loss_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            locked_q  <= locked_d;
        end
    end

    assign m_axis_tdata        = tdata_q;
    assign m_axis_tvalid       = tvalid_q;
    assign m_axis_tlast        = tlast_q;
    assign rx_locked_out       = locked_q;
    assign bit_offset_out      = offset_q;
    assign hdr_err_count_out   = hdr_err_q;
    assign lock_loss_count_out = loss_q;

endmodule

// File: tb/tb_gty_rx_frame_aligner.sv
// tb_gty_rx_frame_aligner
//   Directed bench for gty_rx_frame_aligner. A reference word stream orig[]
//   (8-word frames, header at position 0) is serialised and delayed by
//   delay_bits before being presented as 80-bit words. Every payload beat
//   must equal the reference word from two cycles earlier; lock timing,
//   offsets and counters are checked against hand-derived cycle numbers.
module tb_gty_rx_frame_aligner;

    localparam logic [15:0] SYNC = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rx_reset_in;
    logic [79:0] rx_data;
    logic        rx_active_in;
    logic [79:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        locked;
    logic [6:0]  offset;
    logic [15:0] hdr_err;
    logic [7:0]  loss;

    always #5 clk = ~clk;

    gty_rx_frame_aligner #(
        .SYNC_WORD   (SYNC),
        .FRAME_LEN   (8),
        .VERIFY_COUNT(4),
        .MISS_LIMIT  (3)
    ) dut (
        .m_axis_aclk         (clk),
        .rx_reset_in         (rx_reset_in),
        .gtwiz_userdata_rx_in(rx_data),
        .rx_active_in        (rx_active_in),
        .m_axis_tdata        (tdata),
        .m_axis_tvalid       (tvalid),
        .m_axis_tlast        (tlast),
        .rx_locked_out       (locked),
        .bit_offset_out      (offset),
        .hdr_err_count_out   (hdr_err),
        .lock_loss_count_out (loss)
    );

    logic [79:0] orig_mem [0:8191];
    int unsigned n;
    int unsigned delay_bits;
    int unsigned corrupt_left;
    int unsigned spurious_idx;
    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned beats;
    int unsigned lasts;

    task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    task automatic gen_word(input int unsigned m, output logic [79:0] w);
        int unsigned pos;
        pos = m % 8;
        if (m == spurious_idx) begin
            w = {SYNC, 64'h0};
        end else if (pos == 0) begin
            if (corrupt_left > 0) begin
                corrupt_left--;
                w = '0;
            end else begin
                w = {SYNC, 64'h0};
            end
        end else begin
            w = {32'h0, 16'(m / 8), 32'(pos)};
        end
    endtask

    task automatic drive_next();
        int unsigned m;
        logic [79:0] w;
        m = n + 1;
        gen_word(m, w);
        orig_mem[m] = w;
        rx_data = (orig_mem[m] << delay_bits) | (orig_mem[m-1] >> (80 - delay_bits));
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        #1;
        if (n > 7000) begin
            $display("FAIL cycle_budget: got %0d expected below 7000", n);
            $fatal(1);
        end
        if (tvalid) begin
            beats++;
            if (tlast) lasts++;
            check_eq("beat_not_hdr", ((n - 2) % 8) != 0, 1'b1);
            check_eq("beat_data", tdata, orig_mem[n-2]);
            check_eq("beat_last", tlast, ((n - 2) % 8) == 7);
        end
        drive_next();
    endtask

    task automatic wait_lock(input string tag, input int unsigned budget, output int unsigned at);
        for (int i = 0; i < budget && !locked; i++) tick();
        check_eq(tag, locked, 1'b1);
        at = n;
    endtask

    // Deassert reset so that the first active edge r satisfies r % 8 == res.
    task automatic release_reset(input int unsigned res, output int unsigned r);
        while ((n % 8) != ((res + 7) % 8)) tick();
        rx_reset_in = 1'b0;
        r = n + 1;
    endtask

    initial begin
        int unsigned r;
        int unsigned at;
        int unsigned a;
        int unsigned nl;
        logic found;

        n            = 0;
        n_checks     = 0;
        n_fail       = 0;
        beats        = 0;
        lasts        = 0;
        delay_bits   = 0;
        corrupt_left = 0;
        spurious_idx = 32'hFFFF_FFFF;
        rx_reset_in  = 1'b1;
        rx_active_in = 1'b1;
        orig_mem[0]  = '0;
        drive_next();
        repeat (4) tick();

        check_eq("rst_tvalid", tvalid, 1'b0);
        check_eq("rst_tlast", tlast, 1'b0);
        check_eq("rst_tdata", tdata, 80'h0);
        check_eq("rst_locked", locked, 1'b0);
        check_eq("rst_offset", offset, 7'd0);
        check_eq("rst_hdr_err", hdr_err, 16'd0);
        check_eq("rst_loss", loss, 8'd0);

        // Aligned stream: first edge r has zeroed cur/prev, so the header is
        // first seen at offset 0 on r+80, then three more headers to lock.
        release_reset(2, r);
        wait_lock("t1_lock", 200, at);
        check_eq("t1_lock_cycle", at, r + 104);
        check_eq("t1_offset", offset, 7'd0);
        beats = 0;
        lasts = 0;
        repeat (24) tick();
        check_eq("t1_beats", beats, 21);
        check_eq("t1_lasts", lasts, 3);
        check_eq("t1_offset_hold", offset, 7'd0);

        // rx_active low for 5 edges; first active edge a lands on a header.
        while ((n % 8) != 4) tick();
        rx_active_in = 1'b0;
        a = n + 6;
        tick();
        check_eq("t2_unlocked", locked, 1'b0);
        check_eq("t2_tvalid", tvalid, 1'b0);
        repeat (4) tick();
        check_eq("t2_offset_held", offset, 7'd0);
        check_eq("t2_loss_held", loss, 8'd0);
        check_eq("t2_hdr_held", hdr_err, 16'd0);
        rx_active_in = 1'b1;
        wait_lock("t2_relock", 60, at);
        check_eq("t2_relock_cycle", at, a + 24);

        // Two bad headers: counted, lock and payload kept.
        corrupt_left = 2;
        beats = 0;
        repeat (32) tick();
        check_eq("t3_hdr_err2", hdr_err, 16'd2);
        check_eq("t3_still_locked", locked, 1'b1);
        check_eq("t3_loss0", loss, 8'd0);
        check_eq("t3_beats", beats, 28);

        // Three bad headers: lock drops on the third.
        corrupt_left = 3;
        for (int i = 0; i < 48 && locked; i++) tick();
        check_eq("t3_dropped", locked, 1'b0);
        check_eq("t3_hdr_err5", hdr_err, 16'd5);
        check_eq("t3_loss1", loss, 8'd1);
        check_eq("t3_drop_tvalid", tvalid, 1'b0);
        check_eq("t3_offset_kept", offset, 7'd0);
        nl = n;
        // Offset returns to 0 at edge nl+81; plant a SYNC in payload there.
        spurious_idx = nl + 79;
        tick();
        check_eq("t3_next_tvalid", tvalid, 1'b0);

        beats = 0;
        while (n < nl + 88) tick();
        check_eq("t5_verify_offset", offset, 7'd0);
        tick();
        check_eq("t5_rehunt_offset", offset, 7'd1);
        check_eq("t5_unlocked", locked, 1'b0);
        check_eq("t5_no_beats", beats, 0);

        // Reset clears counters; restart with the stream delayed by 37 bits.
        rx_reset_in = 1'b1;
        #1;
        check_eq("t4_rst_hdr_err", hdr_err, 16'd0);
        check_eq("t4_rst_loss", loss, 8'd0);
        delay_bits   = 37;
        spurious_idx = 32'hFFFF_FFFF;
        repeat (3) tick();
        release_reset(5, r);
        wait_lock("t4_lock", 150, at);
        check_eq("t4_lock_cycle", at, r + 61);
        check_eq("t4_offset", offset, 7'd37);
        beats = 0;
        lasts = 0;
        repeat (24) tick();
        check_eq("t4_beats", beats, 21);
        check_eq("t4_lasts", lasts, 3);

        // Reset on the 4th payload word of a locked frame.
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            tick();
            found = tvalid && (((n - 2) % 8) == 4);
        end
        check_eq("t6_found_word4", found, 1'b1);
        rx_reset_in = 1'b1;
        #1;
        check_eq("t6_tvalid", tvalid, 1'b0);
        check_eq("t6_tlast", tlast, 1'b0);
        check_eq("t6_tdata", tdata, 80'h0);
        check_eq("t6_locked", locked, 1'b0);
        check_eq("t6_offset", offset, 7'd0);
        delay_bits = 0;
        repeat (3) tick();
        release_reset(2, r);
        wait_lock("t6_relock", 200, at);
        check_eq("t6_relock_cycle", at, r + 104);
        check_eq("t6_relock_offset", offset, 7'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
